// File: rtl/arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and
// the default sizing constants used by the core.
package arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  localparam int DEF_NUM_REQ  = 2;
  localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin winner search. The search begins one position
// after last_owner and wraps, so the most recent owner has lowest priority.
module rr_picker
  import arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] request,
  input  logic [IDX_W-1:0]   last_owner,
  output logic               found,
  output logic [IDX_W-1:0]   winner
);

  // First requester at or after last_owner+1 (mod NUM_REQ) wins.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_owner) + k) % NUM_REQ;
      if (!found && request[idx]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/arbiter_rr_core.sv
// Round-robin arbiter with bounded hold time. Every grant is registered;
// a mandatory one-cycle GAP separates consecutive grants so each handover
// produces a fresh rising edge on the grant line.
module arbiter_rr_core
  import arbiter_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         request,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic                       preempt
);

  localparam int         IDX_W    = $clog2(NUM_REQ);
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  arb_state_t         state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [IDX_W-1:0]   owner_nxt;
  logic [IDX_W-1:0]   last_owner, last_owner_nxt;
  logic [7:0]         hold_cnt, hold_cnt_nxt;
  logic               busy_nxt, preempt_nxt;
  logic               armed;
  logic               found;
  logic [IDX_W-1:0]   winner;
  logic               owner_req;
  logic               others_wait;

  // Hold counter increment that sticks at the limit instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= HOLD_LIM) ? HOLD_LIM : v + 8'd1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .request    (request),
    .last_owner (last_owner),
    .found      (found),
    .winner     (winner)
  );

  assign owner_req   = request[owner];
  assign others_wait = |(request & ~onehot(owner));

  // Next-state and registered-output decode; defaults hold current values.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    owner_nxt      = owner;
    busy_nxt       = busy;
    preempt_nxt    = 1'b0;
    hold_cnt_nxt   = hold_cnt;
    last_owner_nxt = last_owner;
    case (state)
      IDLE: begin
        // armed stays low for the first edge after reset release, which
        // pushes the earliest possible grant to the second edge.
        if (armed && found) begin
          state_nxt    = GRANT;
          grant_nxt    = onehot(winner);
          owner_nxt    = winner;
          busy_nxt     = 1'b1;
          hold_cnt_nxt = 8'd1;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_nxt      = GAP;
          grant_nxt      = '0;
          busy_nxt       = 1'b0;
          hold_cnt_nxt   = 8'd0;
          last_owner_nxt = owner;
        end else if ((hold_cnt >= HOLD_LIM) && others_wait) begin
          state_nxt      = GAP;
          grant_nxt      = '0;
          busy_nxt       = 1'b0;
          preempt_nxt    = 1'b1;
          hold_cnt_nxt   = 8'd0;
          last_owner_nxt = owner;
        end else begin
          hold_cnt_nxt = sat_inc(hold_cnt);
        end
      end
      GAP: begin
        // last_owner was updated on the removal edge, so the picker already
        // starts its search after the previous holder.
        if (found) begin
          state_nxt    = GRANT;
          grant_nxt    = onehot(winner);
          owner_nxt    = winner;
          busy_nxt     = 1'b1;
          hold_cnt_nxt = 8'd1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      busy       <= 1'b0;
      preempt    <= 1'b0;
      hold_cnt   <= 8'd0;
      last_owner <= IDX_W'(NUM_REQ - 1);
      armed      <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      owner      <= owner_nxt;
      busy       <= busy_nxt;
      preempt    <= preempt_nxt;
      hold_cnt   <= hold_cnt_nxt;
      last_owner <= last_owner_nxt;
      armed      <= 1'b1;
    end
  end

endmodule
